// File: rtl/time_set_entry.sv
// time_set_entry
//   Operator entry front-end for the countdown timer. Four raw push-buttons are
//   synchronised, debounced and edge-detected; the resulting press events drive a
//   small edit FSM that keeps minute/second working values and commits them to
//   minSet/secSet with a one-cycle set strobe.
//
// Ports
//   clk       in   1  system clock, rising edge
//   rst       in   1  asynchronous, active-low reset
//   btnMode   in   1  raw button: enter edit from IDLE, then toggle min/sec field
//   btnInc    in   1  raw button: +1 to selected field (wraps 59 -> 0)
//   btnDec    in   1  raw button: -1 to selected field (wraps 0 -> 59)
//   btnEnter  in   1  raw button: commit working values
//   minSet    out  6  committed minutes, 0..59
//   secSet    out  6  committed seconds, 0..59
//   set       out  1  one-cycle load strobe, minSet/secSet valid while high
//   editing   out  1  high in EDIT_MIN / EDIT_SEC
//   fieldSel  out  1  0 = minutes, 1 = seconds (0 outside edit)
module time_set_entry #(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned DEB_W      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btnMode,
  input  logic       btnInc,
  input  logic       btnDec,
  input  logic       btnEnter,
  output logic [5:0] minSet,
  output logic [5:0] secSet,
  output logic       set,
  output logic       editing,
  output logic       fieldSel
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EDIT_MIN = 2'd1,
    EDIT_SEC = 2'd2,
    COMMIT   = 2'd3
  } state_t;

  localparam int unsigned B_MODE  = 0;
  localparam int unsigned B_INC   = 1;
  localparam int unsigned B_DEC   = 2;
  localparam int unsigned B_ENTER = 3;

  // ---------------------------------------------------------------------------
  // Button path: 2-flop synchroniser -> debouncer -> rising-edge detect.
  // The four buttons share one vectorised datapath.
  // ---------------------------------------------------------------------------
  logic [3:0]       raw;
  logic [3:0]       sync1_q, sync2_q;
  logic [3:0]       lvl_q, lvl_prev_q;
  logic [DEB_W-1:0] cnt_q [4];
  logic [3:0]       ev;

  assign raw = {btnEnter, btnDec, btnInc, btnMode};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      lvl_q      <= '0;
      lvl_prev_q <= '0;
      for (int unsigned i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      lvl_prev_q <= lvl_q;
      for (int unsigned i = 0; i < 4; i++) begin
        // The counter tallies consecutive samples that disagree with the accepted
        // level; the DEB_CYCLES-th such sample flips the level.
        if (sync2_q[i] == lvl_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == DEB_W'(DEB_CYCLES - 1)) begin
          lvl_q[i] <= sync2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign ev = lvl_q & ~lvl_prev_q;

  // ---------------------------------------------------------------------------
  // Edit FSM and working/committed registers
  // ---------------------------------------------------------------------------
  state_t     state_q, state_d;
  logic [5:0] minWork_q, minWork_d;
  logic [5:0] secWork_q, secWork_d;
  logic [5:0] minSet_q, minSet_d;
  logic [5:0] secSet_q, secSet_d;

  function automatic logic [5:0] inc60(input logic [5:0] v);
    return (v >= 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] dec60(input logic [5:0] v);
    return (v == 6'd0) ? 6'd59 : v - 6'd1;
  endfunction

  always_comb begin
    state_d   = state_q;
    minWork_d = minWork_q;
    secWork_d = secWork_q;
    minSet_d  = minSet_q;
    secSet_d  = secSet_q;
    case (state_q)
      IDLE: begin
        if (ev[B_MODE]) begin
          state_d   = EDIT_MIN;
          minWork_d = minSet_q;
          secWork_d = secSet_q;
        end
      end
      EDIT_MIN, EDIT_SEC: begin
        // Single priority chain: Enter > Mode > Inc > Dec.
        if (ev[B_ENTER]) begin
          state_d  = COMMIT;
          minSet_d = minWork_q;
          secSet_d = secWork_q;
        end else if (ev[B_MODE]) begin
          state_d = (state_q == EDIT_MIN) ? EDIT_SEC : EDIT_MIN;
        end else if (ev[B_INC]) begin
          if (state_q == EDIT_MIN) minWork_d = inc60(minWork_q);
          else                     secWork_d = inc60(secWork_q);
        end else if (ev[B_DEC]) begin
          if (state_q == EDIT_MIN) minWork_d = dec60(minWork_q);
          else                     secWork_d = dec60(secWork_q);
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      minWork_q <= '0;
      secWork_q <= '0;
      minSet_q  <= '0;
      secSet_q  <= '0;
    end else begin
      state_q   <= state_d;
      minWork_q <= minWork_d;
      secWork_q <= secWork_d;
      minSet_q  <= minSet_d;
      secSet_q  <= secSet_d;
    end
  end

  // set is decoded from the registered COMMIT state, so a reset during COMMIT
  // removes the pulse immediately.
  assign minSet   = minSet_q;
  assign secSet   = secSet_q;
  assign set      = (state_q == COMMIT);
  assign editing  = (state_q == EDIT_MIN) || (state_q == EDIT_SEC);
  assign fieldSel = (state_q == EDIT_SEC);

endmodule

// File: tb/tb_time_set_entry.sv
// tb_time_set_entry
//   Directed bench for time_set_entry. Expected commits are queued as Enter
//   presses are issued; a monitor records every set pulse and the main sequence
//   matches recorded commits against the expectation queue.
module tb_time_set_entry;

  logic       clk = 1'b0;
  logic       rst;
  logic       btnMode, btnInc, btnDec, btnEnter;
  logic [5:0] minSet, secSet;
  logic       set, editing, fieldSel;

  time_set_entry #(.DEB_CYCLES(4), .DEB_W(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .btnMode  (btnMode),
    .btnInc   (btnInc),
    .btnDec   (btnDec),
    .btnEnter (btnEnter),
    .minSet   (minSet),
    .secSet   (secSet),
    .set      (set),
    .editing  (editing),
    .fieldSel (fieldSel)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] M_MODE  = 4'b0001;
  localparam logic [3:0] M_INC   = 4'b0010;
  localparam logic [3:0] M_DEC   = 4'b0100;
  localparam logic [3:0] M_ENTER = 4'b1000;

  int n_cmp = 0;
  int n_err = 0;

  logic [11:0] exp_q[$];
  logic [11:0] got_q[$];
  int          rd = 0;
  int          wide_n = 0;
  logic        set_prev = 1'b0;

  // Monitor: owns got_q and wide_n.
  always @(negedge clk) begin
    if (set) got_q.push_back({minSet, secSet});
    if (set && set_prev) wide_n++;
    set_prev = set;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] m);
    {btnEnter, btnDec, btnInc, btnMode} = m;
  endtask

  task automatic press(input logic [3:0] m, input int n = 1);
    for (int k = 0; k < n; k++) begin
      drive(m);
      repeat (10) @(negedge clk);
      drive(4'b0000);
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic expect_commit(input int mn, input int sc);
    exp_q.push_back({6'(mn), 6'(sc)});
  endtask

  task automatic drain();
    logic [11:0] e, g;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("commit_present", got_q.size(), rd + 1);
      if (rd < got_q.size()) begin
        g = got_q[rd];
        rd++;
        check("commit_min", int'(g[11:6]), int'(e[11:6]));
        check("commit_sec", int'(g[5:0]), int'(e[5:0]));
      end
    end
    check("set_count", got_q.size(), rd);
  endtask

  initial begin
    rst = 1'b0;
    drive(4'b0000);
    repeat (3) @(negedge clk);
    check("rst_min", minSet, 0);
    check("rst_sec", secSet, 0);
    check("rst_set", set, 0);
    check("rst_editing", editing, 0);
    check("rst_fieldsel", fieldSel, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Mode press timing: raw high before edge N, event consumed at edge N+6.
    drive(M_MODE);
    repeat (6) @(posedge clk);
    #1 check("mode_before_n6", editing, 0);
    @(posedge clk);
    #1 check("mode_at_n6", editing, 1);
    check("edit_min_field", fieldSel, 0);
    @(negedge clk);
    repeat (3) @(negedge clk);
    drive(4'b0000);
    repeat (10) @(negedge clk);

    // Basic edit: min 0->3, sec 0->59, commit.
    press(M_INC, 3);
    press(M_MODE);
    check("edit_sec_field", fieldSel, 1);
    press(M_DEC);
    expect_commit(3, 59);
    press(M_ENTER);
    drain();
    check("post_commit_editing", editing, 0);
    check("post_commit_min", minSet, 3);
    check("post_commit_sec", secSet, 59);

    // Glitch rejection, then one increment from a 10-cycle hold.
    press(M_MODE);
    drive(M_INC);
    repeat (2) @(negedge clk);
    drive(4'b0000);
    repeat (10) @(negedge clk);
    press(M_INC);                 // min 3 -> 4
    press(M_DEC, 5);              // 4 -> 0 -> 59
    expect_commit(59, 59);
    press(M_ENTER);
    drain();
    press(M_MODE);
    press(M_INC);                 // 59 -> 0
    expect_commit(0, 59);
    press(M_ENTER);
    drain();

    // Same-cycle events: Enter beats Inc, Mode beats Dec.
    press(M_MODE);
    press(M_MODE);
    check("sec_field_again", fieldSel, 1);
    expect_commit(0, 59);
    press(M_ENTER | M_INC);
    drain();
    check("enter_inc_idle", editing, 0);
    press(M_MODE, 2);
    press(M_MODE | M_DEC);
    check("mode_dec_field", fieldSel, 0);
    check("mode_dec_editing", editing, 1);
    expect_commit(0, 59);
    press(M_ENTER);
    drain();

    // Commit 12:34, then 13:34; IDLE ignores Inc/Enter.
    press(M_MODE);
    press(M_INC, 12);
    press(M_MODE);
    press(M_DEC, 25);             // 59 -> 34
    expect_commit(12, 34);
    press(M_ENTER);
    drain();
    press(M_MODE);
    press(M_INC);
    expect_commit(13, 34);
    press(M_ENTER);
    drain();
    press(M_INC);
    press(M_ENTER);
    drain();
    check("idle_min_hold", minSet, 13);
    check("idle_sec_hold", secSet, 34);

    // Asynchronous reset mid-edit discards everything.
    press(M_MODE);
    press(M_INC, 2);
    rst = 1'b0;
    #1;
    check("midrst_min", minSet, 0);
    check("midrst_sec", secSet, 0);
    check("midrst_editing", editing, 0);
    check("midrst_set", set, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    press(M_ENTER);
    drain();
    press(M_MODE);
    expect_commit(0, 0);
    press(M_ENTER);
    drain();
    check("set_width_violations", wide_n, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
